multi_controller_interface: RTL and testbench
=============================================

# multi_controller_interface

Polls NUM_CONTROLLERS NES-style serial shift-register gamepads that share one latch line and one shift strobe. Each poll produces a registered per-controller button word and sticky newly-pressed/newly-released flags. It is the parametrised successor to the fixed two-controller, 8-button reader and sits between the controller pins and the CPU-visible controller registers. A poll is normally started once per frame from vblank.

## Interface
Parameters:
- NUM_CONTROLLERS, 2, number of gamepads polled in parallel (>=1)
- NUM_BUTTONS, 8, serial bits per gamepad (>=2)
- BIT_CYCLES, 4, clk cycles per serial bit period (>=1)

Ports:
- clk  in  1  single system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle poll request; ignored while busy
- edge_clear  in  1  one-cycle clear of all pressed/released flags
- controller_data_in_B  in  NUM_CONTROLLERS  serial data from each gamepad, active-low (0 = button held)
- controller_latch  out  1  parallel-load strobe shared by all gamepads
- controller_clk_enable  out  1  one-cycle shift strobe shared by all gamepads
- buttons_out  out  NUM_CONTROLLERS*NUM_BUTTONS  active-high button state; controller c occupies bits [c*NUM_BUTTONS +: NUM_BUTTONS]
- pressed_out  out  NUM_CONTROLLERS*NUM_BUTTONS  sticky 0->1 transitions since the last clear
- released_out  out  NUM_CONTROLLERS*NUM_BUTTONS  sticky 1->0 transitions since the last clear
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse on the commit cycle

## Operation
- States:
  - IDLE: busy=0. start=1 goes to LATCH and clears the bit counter and index.
  - LATCH: controller_latch=1 for exactly BIT_CYCLES cycles, then go to SHIFT.
  - SHIFT: the bit counter runs 0..BIT_CYCLES-1. When the counter reaches BIT_CYCLES-1:
    - Sample ~controller_data_in_B[c] into shift-register bit (NUM_BUTTONS-1-index) of each channel. The first serial bit goes to the MSB.
    - If index < NUM_BUTTONS-1, assert controller_clk_enable for that one cycle and increment index.
    - Otherwise go to COMMIT.
  - COMMIT: one cycle, then go to IDLE. On this cycle:
    - buttons_out <= shift
    - pressed_out <= pressed_out | (shift & ~buttons_out)
    - released_out <= released_out | (~shift & buttons_out)
    - done=1
- edge_clear=1 zeroes pressed_out and released_out.
  - If edge_clear coincides with COMMIT, the clear applies to the old flags and this poll's new edges are still set.
- start while busy, or on the COMMIT cycle, is dropped. No queueing.
- buttons_out changes only on COMMIT. It is never partially updated.
- Counter widths are $clog2(BIT_CYCLES) and $clog2(NUM_BUTTONS), with a minimum width of 1. Counters never exceed their terminal value.

## Timing
- Reset values:
  - state = IDLE
  - controller_latch, controller_clk_enable, busy, done = 0
  - buttons_out, pressed_out, released_out and the shift registers = all 0
- rst asserted mid-poll aborts immediately. The latch and strobe drop asynchronously, and there is no partial commit.
- Start accepted at cycle 0. The latch is high during cycles 1..BIT_CYCLES.
- Bit k is sampled at cycle BIT_CYCLES*(k+2).
- Strobe k (k = 0..NUM_BUTTONS-2) coincides with sample k.
- done occurs at cycle BIT_CYCLES*(NUM_BUTTONS+1)+1. Outputs are valid from the following cycle.
- busy is high for cycles 1..done inclusive.
- Gamepads present bit 0 after the latch falls. They shift on the clk edge where controller_clk_enable=1, and the next bit is sampled one full BIT_CYCLES later.

## Structure
- Shared package controller_pkg holds:
  - the state enum (IDLE, LATCH, SHIFT, COMMIT)
  - default constants DEFAULT_NUM_BUTTONS=8 and DEFAULT_BIT_CYCLES=4
- Sub-module controller_channel holds one channel's NUM_BUTTONS shift register, committed button word and sticky edge flags.
  - It is instantiated NUM_CONTROLLERS times in a generate loop.
  - It is driven by the shared sample, commit and clear strobes from the top-level FSM.
- The FSM, bit counter and index live only in the top level.

## Test plan
All scenarios use NUM_CONTROLLERS=2, NUM_BUTTONS=8, BIT_CYCLES=4, with behavioural shift-register gamepads.
- Basic poll: pads hold 8'b10001001 and 8'b00100110; pulse start -> done at cycle 37; buttons_out=16'b00100110_10001001; latch high for cycles 1-4; exactly 7 strobes.
- Edges: poll 8'h00, then 8'h81, then 8'h01 -> after the second poll pressed=8'h81 on channel 0; after the third, released=8'h80 and pressed is still 8'h81.
- Clear collision: edge_clear on the COMMIT cycle of a poll going 8'h01->8'h03 -> pressed=8'h02 only.
- Busy start: extra start pulses at cycles 5 and 20 -> ignored; a single done at 37. A start on cycle 38 starts a new poll.
- Reset mid-poll: rst at cycle 15 of a poll -> latch, strobe and busy=0 immediately; buttons_out keeps its reset 0; the next start completes normally.
- Parameter sweep: NUM_CONTROLLERS=4, NUM_BUTTONS=12, BIT_CYCLES=1 -> done at cycle 14; each channel matches its pad pattern.

Source files
------------

// File: rtl/controller_pkg.sv
// Shared types and defaults for the serial gamepad poller.
package controller_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LATCH  = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    localparam int DEFAULT_NUM_BUTTONS = 8;
    localparam int DEFAULT_BIT_CYCLES  = 4;

    // Counter width for a counter that runs 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/controller_channel.sv
// One gamepad channel: serial capture register, committed button word and
// sticky press/release flags. All strobes come from the shared top-level FSM.
module controller_channel
    import controller_pkg::*;
#(
    parameter int NUM_BUTTONS = DEFAULT_NUM_BUTTONS,
    parameter int IW          = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_sample,
    input  logic                   i_commit,
    input  logic                   i_clear,
    input  logic                   i_data_b,
    input  logic [IW-1:0]          i_idx,
    output logic [NUM_BUTTONS-1:0] o_buttons,
    output logic [NUM_BUTTONS-1:0] o_pressed,
    output logic [NUM_BUTTONS-1:0] o_released
);

    logic [NUM_BUTTONS-1:0] r_shift;
    logic [NUM_BUTTONS-1:0] r_buttons;
    logic [NUM_BUTTONS-1:0] r_pressed;
    logic [NUM_BUTTONS-1:0] r_released;

    // Capture serial bit 'index' into position NUM_BUTTONS-1-index; publish whole word on commit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift   <= '0;
            r_buttons <= '0;
        end else begin
            if (i_sample) begin
                for (int i = 0; i < NUM_BUTTONS; i++) begin
                    if (i_idx == IW'(NUM_BUTTONS - 1 - i)) begin
                        r_shift[i] <= ~i_data_b;
                    end
                end
            end
            if (i_commit) begin
                r_buttons <= r_shift;
            end
        end
    end

    // Sticky edge flags; a clear on the commit cycle wipes only the old flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pressed  <= '0;
            r_released <= '0;
        end else begin
            r_pressed  <= (i_clear ? '0 : r_pressed)
                        | (i_commit ? (r_shift & ~r_buttons) : '0);
            r_released <= (i_clear ? '0 : r_released)
                        | (i_commit ? (~r_shift & r_buttons) : '0);
        end
    end

    assign o_buttons  = r_buttons;
    assign o_pressed  = r_pressed;
    assign o_released = r_released;

endmodule

// File: rtl/multi_controller_interface.sv
// Polls NUM_CONTROLLERS NES-style gamepads over a shared latch/strobe pair.
// Handshake: start is a single-cycle request sampled only in IDLE; busy is
// high from the next cycle through the done pulse; done marks the cycle on
// which all button words and edge flags update together.
module multi_controller_interface
    import controller_pkg::*;
#(
    parameter int NUM_CONTROLLERS = 2,
    parameter int NUM_BUTTONS     = DEFAULT_NUM_BUTTONS,
    parameter int BIT_CYCLES      = DEFAULT_BIT_CYCLES
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   edge_clear,
    input  logic [NUM_CONTROLLERS-1:0]             controller_data_in_B,
    output logic                                   controller_latch,
    output logic                                   controller_clk_enable,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] buttons_out,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] pressed_out,
    output logic [NUM_CONTROLLERS*NUM_BUTTONS-1:0] released_out,
    output logic                                   busy,
    output logic                                   done,
    output state_t                                 dbg_state
);

    localparam int CW = cnt_width(BIT_CYCLES);
    localparam int IW = cnt_width(NUM_BUTTONS);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_BUTTONS - 1);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [IW-1:0]   r_idx;
    logic            w_latch;
    logic            w_strobe;
    logic            w_sample;
    logic            w_commit;

    // State register plus bit-period counter and serial bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == LATCH || r_state == SHIFT) begin
                r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (r_state == IDLE) begin
                r_idx <= '0;
            end else if (w_strobe) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_strobe = 1'b0;
        w_sample = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = LATCH;
            end
            LATCH: begin
                w_latch = 1'b1;
                if (r_cnt == CNT_LAST) w_next = SHIFT;
            end
            SHIFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_sample = 1'b1;
                    if (r_idx != IDX_LAST) w_strobe = 1'b1;
                    else                   w_next   = COMMIT;
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign controller_latch      = w_latch;
    assign controller_clk_enable = w_strobe;
    assign busy                  = (r_state != IDLE);
    assign done                  = w_commit;
    assign dbg_state             = r_state;

    for (genvar c = 0; c < NUM_CONTROLLERS; c++) begin : g_ch
        controller_channel #(
            .NUM_BUTTONS (NUM_BUTTONS),
            .IW          (IW)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_sample   (w_sample),
            .i_commit   (w_commit),
            .i_clear    (edge_clear),
            .i_data_b   (controller_data_in_B[c]),
            .i_idx      (r_idx),
            .o_buttons  (buttons_out[c*NUM_BUTTONS +: NUM_BUTTONS]),
            .o_pressed  (pressed_out[c*NUM_BUTTONS +: NUM_BUTTONS]),
            .o_released (released_out[c*NUM_BUTTONS +: NUM_BUTTONS])
        );
    end

endmodule

// File: tb/tb_multi_controller_interface.sv
// Bench for the gamepad poller: default 2x8x4 instance plus a 4x12x1 instance,
// each fed by behavioural shift-register gamepads.
module tb_multi_controller_interface;
    import controller_pkg::*;

    localparam int COMMIT_CYC = 37;
    localparam int BUDGET     = 100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT 1 (2 x 8 x 4) ----------------
    logic        start, edge_clear;
    logic [1:0]  data_b;
    logic        latch, clk_en, busy, done;
    logic [15:0] buttons, pressed, released;
    state_t      dbg;

    multi_controller_interface #(.NUM_CONTROLLERS(2), .NUM_BUTTONS(8), .BIT_CYCLES(4)) u_dut (
        .clk(clk), .rst(rst), .start(start), .edge_clear(edge_clear),
        .controller_data_in_B(data_b), .controller_latch(latch),
        .controller_clk_enable(clk_en), .buttons_out(buttons),
        .pressed_out(pressed), .released_out(released),
        .busy(busy), .done(done), .dbg_state(dbg)
    );

    // ---------------- DUT 2 (4 x 12 x 1) ----------------
    logic        start2, edge_clear2;
    logic [3:0]  data2_b;
    logic        latch2, clk_en2, busy2, done2;
    logic [47:0] buttons2, pressed2, released2;
    state_t      dbg2;

    multi_controller_interface #(.NUM_CONTROLLERS(4), .NUM_BUTTONS(12), .BIT_CYCLES(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .edge_clear(edge_clear2),
        .controller_data_in_B(data2_b), .controller_latch(latch2),
        .controller_clk_enable(clk_en2), .buttons_out(buttons2),
        .pressed_out(pressed2), .released_out(released2),
        .busy(busy2), .done(done2), .dbg_state(dbg2)
    );

    // ---------------- behavioural gamepads ----------------
    logic [7:0]  pad_pat[2];
    logic [7:0]  pad_sr[2];
    logic [11:0] pad2_pat[4];
    logic [11:0] pad2_sr[4];

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (latch)       pad_sr[c] <= pad_pat[c];
            else if (clk_en) pad_sr[c] <= pad_sr[c] << 1;
        end
        for (int c = 0; c < 4; c++) begin
            if (latch2)       pad2_sr[c] <= pad2_pat[c];
            else if (clk_en2) pad2_sr[c] <= pad2_sr[c] << 1;
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) data_b[c] = ~pad_sr[c][7];
        for (int c = 0; c < 4; c++) data2_b[c] = ~pad2_sr[c][11];
    end

    // ---------------- scoreboard ----------------
    logic [47:0] exp_q[$];
    logic [15:0] m_buttons, m_pressed, m_released;
    int tests = 0;
    int fails = 0;

    // Driver: run one poll on DUT 1. Pushes the expected {buttons,pressed,released}
    // and returns timing observations plus the outputs seen one cycle after done.
    task automatic drive_poll(input logic [15:0] pat, input int xs1, input int xs2,
                              input bit clr_commit,
                              output int done_cyc, output int done_cnt,
                              output int latch_first, output int latch_last,
                              output int latch_cnt, output int strobe_cnt,
                              output int busy_cnt, output logic busy_after,
                              output logic [47:0] obs);
        logic [15:0] np, nr;
        pad_pat[0] = pat[7:0];
        pad_pat[1] = pat[15:8];
        np = (clr_commit ? 16'h0 : m_pressed)  | (pat & ~m_buttons);
        nr = (clr_commit ? 16'h0 : m_released) | (~pat & m_buttons);
        m_buttons  = pat;
        m_pressed  = np;
        m_released = nr;
        exp_q.push_back({pat, np, nr});
        done_cyc = -1; done_cnt = 0; latch_first = -1; latch_last = -1;
        latch_cnt = 0; strobe_cnt = 0; busy_cnt = 0;
        start = 1'b1;
        for (int n = 0; n <= BUDGET; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                start      = (n == xs1) || (n == xs2);
                edge_clear = clr_commit && (n == COMMIT_CYC);
            end
            @(negedge clk);
            if (latch) begin
                if (latch_first < 0) latch_first = n;
                latch_last = n;
                latch_cnt++;
            end
            if (clk_en) strobe_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            if (done_cyc >= 0) break;
        end
        @(posedge clk); #1;
        start      = 1'b0;
        edge_clear = 1'b0;
        obs        = {buttons, pressed, released};
        busy_after = busy;
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        edge_clear = 1'b1;
        @(posedge clk); #1;
        edge_clear = 1'b0;
        m_pressed  = '0;
        m_released = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 0; edge_clear = 0; start2 = 0; edge_clear2 = 0;
        m_buttons = '0; m_pressed = '0; m_released = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (buttons !== 16'h0)  begin fails++; $display("FAIL reset_buttons got %h exp 0000", buttons); end
        tests++; if (pressed !== 16'h0)  begin fails++; $display("FAIL reset_pressed got %h exp 0000", pressed); end
        tests++; if (released !== 16'h0) begin fails++; $display("FAIL reset_released got %h exp 0000", released); end
        tests++; if ({latch, clk_en, busy, done} !== 4'b0) begin fails++; $display("FAIL reset_ctrl got %b exp 0000", {latch, clk_en, busy, done}); end
        tests++; if (dbg !== IDLE) begin fails++; $display("FAIL reset_state got %0d exp %0d", dbg, IDLE); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dc, dn, lf, ll, lc, sc, bc; logic ba; logic [47:0] obs, exp;
        drive_poll({8'b00100110, 8'b10001001}, -1, -1, 1'b0, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (dc !== 37) begin fails++; $display("FAIL basic_done_cyc got %0d exp 37", dc); end
        tests++; if (lf !== 1 || ll !== 4 || lc !== 4) begin fails++; $display("FAIL basic_latch got %0d..%0d n=%0d exp 1..4 n=4", lf, ll, lc); end
        tests++; if (sc !== 7) begin fails++; $display("FAIL basic_strobes got %0d exp 7", sc); end
        tests++; if (bc !== 37) begin fails++; $display("FAIL basic_busy_cycles got %0d exp 37", bc); end
        tests++; if (ba !== 1'b0) begin fails++; $display("FAIL basic_busy_after got %b exp 0", ba); end
        tests++; if (obs[47:32] !== 16'b00100110_10001001) begin fails++; $display("FAIL basic_buttons got %h exp %h", obs[47:32], 16'b00100110_10001001); end
        tests++; if (obs !== exp) begin fails++; $display("FAIL basic_sb got %h exp %h", obs, exp); end
    endtask

    task automatic test_edges();
        int dc, dn, lf, ll, lc, sc, bc; logic ba; logic [47:0] obs, exp;
        drive_poll(16'h0000, -1, -1, 1'b0, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (obs !== exp) begin fails++; $display("FAIL edges_p1_sb got %h exp %h", obs, exp); end
        pulse_clear();
        drive_poll(16'h0081, -1, -1, 1'b0, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (obs !== exp) begin fails++; $display("FAIL edges_p2_sb got %h exp %h", obs, exp); end
        tests++; if (obs[23:16] !== 8'h81) begin fails++; $display("FAIL edges_p2_pressed got %h exp 81", obs[23:16]); end
        drive_poll(16'h0001, -1, -1, 1'b0, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (obs !== exp) begin fails++; $display("FAIL edges_p3_sb got %h exp %h", obs, exp); end
        tests++; if (obs[7:0] !== 8'h80) begin fails++; $display("FAIL edges_p3_released got %h exp 80", obs[7:0]); end
        tests++; if (obs[23:16] !== 8'h81) begin fails++; $display("FAIL edges_p3_pressed got %h exp 81", obs[23:16]); end
    endtask

    task automatic test_clear_collision();
        int dc, dn, lf, ll, lc, sc, bc; logic ba; logic [47:0] obs, exp;
        drive_poll(16'h0001, -1, -1, 1'b0, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (obs !== exp) begin fails++; $display("FAIL collide_p1_sb got %h exp %h", obs, exp); end
        drive_poll(16'h0003, -1, -1, 1'b1, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (obs[31:16] !== 16'h0002) begin fails++; $display("FAIL collide_pressed got %h exp 0002", obs[31:16]); end
        tests++; if (obs[15:0] !== 16'h0000) begin fails++; $display("FAIL collide_released got %h exp 0000", obs[15:0]); end
        tests++; if (obs !== exp) begin fails++; $display("FAIL collide_sb got %h exp %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        int dc, dn, lf, ll, lc, sc, bc; logic ba; logic [47:0] obs, exp;
        logic [15:0] p;
        p = 16'($urandom_range(0, 65535));
        drive_poll(p, 5, 20, 1'b0, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (dc !== 37 || dn !== 1) begin fails++; $display("FAIL busy_start_done got cyc=%0d n=%0d exp cyc=37 n=1", dc, dn); end
        tests++; if (lc !== 4 || sc !== 7) begin fails++; $display("FAIL busy_start_seq got latch=%0d strobes=%0d exp 4 7", lc, sc); end
        tests++; if (obs !== exp) begin fails++; $display("FAIL busy_start_sb got %h exp %h", obs, exp); end
        // Next poll starts on cycle 38 of the previous one.
        p = 16'($urandom_range(0, 65535));
        drive_poll(p, -1, -1, 1'b0, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (dc !== 37 || lf !== 1) begin fails++; $display("FAIL b2b_timing got done=%0d latch_first=%0d exp 37 1", dc, lf); end
        tests++; if (obs !== exp) begin fails++; $display("FAIL b2b_sb got %h exp %h", obs, exp); end
    endtask

    task automatic test_reset_mid_poll();
        int dc, dn, lf, ll, lc, sc, bc; logic ba; logic [47:0] obs, exp;
        pad_pat[0] = 8'hA5;
        pad_pat[1] = 8'h5A;
        start = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        rst = 1'b1;
        #1;
        tests++; if ({latch, clk_en, busy} !== 3'b0) begin fails++; $display("FAIL midrst_ctrl got %b exp 000", {latch, clk_en, busy}); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_buttons = '0; m_pressed = '0; m_released = '0;
        tests++; if ({buttons, pressed, released} !== 48'h0) begin fails++; $display("FAIL midrst_outputs got %h exp 0", {buttons, pressed, released}); end
        tests++; if (dbg !== IDLE) begin fails++; $display("FAIL midrst_state got %0d exp %0d", dbg, IDLE); end
        repeat (3) begin
            @(posedge clk); #1;
            tests++; if (buttons !== 16'h0) begin fails++; $display("FAIL midrst_no_commit got %h exp 0000", buttons); end
        end
        drive_poll(16'h5AA5, -1, -1, 1'b0, dc, dn, lf, ll, lc, sc, bc, ba, obs);
        exp = exp_q.pop_front();
        tests++; if (dc !== 37) begin fails++; $display("FAIL midrst_repoll_done got %0d exp 37", dc); end
        tests++; if (obs !== exp) begin fails++; $display("FAIL midrst_repoll_sb got %h exp %h", obs, exp); end
    endtask

    task automatic test_param_sweep();
        logic [47:0] pat, exp;
        int dc;
        for (int c = 0; c < 4; c++) begin
            pad2_pat[c] = 12'($urandom_range(0, 4095));
            pat[c*12 +: 12] = pad2_pat[c];
        end
        exp_q.push_back(pat);
        dc = -1;
        start2 = 1'b1;
        for (int n = 0; n <= BUDGET; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
                start2 = 1'b0;
            end
            @(negedge clk);
            if (done2 && dc < 0) dc = n;
            if (dc >= 0) break;
        end
        @(posedge clk); #1;
        exp = exp_q.pop_front();
        tests++; if (dc !== 14) begin fails++; $display("FAIL sweep_done_cyc got %0d exp 14", dc); end
        tests++; if (buttons2 !== exp) begin fails++; $display("FAIL sweep_buttons got %h exp %h", buttons2, exp); end
        tests++; if (pressed2 !== exp) begin fails++; $display("FAIL sweep_pressed got %h exp %h", pressed2, exp); end
        tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL sweep_busy_after got %b exp 0", busy2); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_clear_collision();
        test_back_to_back();
        test_reset_mid_poll();
        test_param_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
